// File: rtl/pll_seq_pkg.sv
// Shared types, parameter defaults and width helper for the PLL lock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  localparam int unsigned RST_HOLD_CYC_DEF      = 32;
  localparam int unsigned LOCK_STABLE_CYC_DEF   = 1024;
  localparam int unsigned LOCK_TIMEOUT_CYC_DEF  = 1048576;
  localparam int unsigned MAX_RETRY_DEF         = 3;
  localparam int unsigned RESET_STRETCH_CYC_DEF = 16;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk (sampling clock), rst (async active-high, clears both flops),
//        d (asynchronous input), q (synchronised output).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: holds PLL in reset, waits for debounced lock, releases a stretched core reset.
// Latency: outputs registered, one cycle after the FSM decision; pll_locked seen 2 cycles late.
// Backpressure: none; relock_req is a level held by the requester until relock_ack pulses.
// Ports: refclk/rst (sole clock, async active-high reset), pll_locked (async PLL status),
//        relock_req/relock_ack (level request, one-cycle acceptance pulse), pll_rst (to PLL),
//        sys_rst (to core), ready, fault, retry_cnt (retries this sequence),
//        lock_loss_cnt (saturating lock losses seen in RUN, cleared only by rst).
// Build option: define PLL_SEQ_AUTORECOVER_EN to leave FAULT after a 2^24-cycle backoff;
//               otherwise FAULT is sticky until rst.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC      = RST_HOLD_CYC_DEF,
  parameter int unsigned LOCK_STABLE_CYC   = LOCK_STABLE_CYC_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYC  = LOCK_TIMEOUT_CYC_DEF,
  parameter int unsigned MAX_RETRY         = MAX_RETRY_DEF,
  parameter int unsigned RESET_STRETCH_CYC = RESET_STRETCH_CYC_DEF,
  localparam int unsigned RW               = cnt_width(MAX_RETRY + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          relock_req,
  output logic          relock_ack,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    lock_loss_cnt
);

  // One phase counter serves HOLD (up), STABLE (up) and the RUN stretch (down),
  // since those phases never overlap; the timeout counter spans WAIT_LOCK+STABLE.
  localparam int unsigned PH_MAX_A = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int unsigned PH_MAX   = (PH_MAX_A > RESET_STRETCH_CYC) ? PH_MAX_A : RESET_STRETCH_CYC;
  localparam int unsigned CW       = cnt_width(PH_MAX);
  localparam int unsigned TW       = cnt_width(LOCK_TIMEOUT_CYC);

  pll_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_d;
  logic [7:0]    llc_d;
  logic          lock_s;
  logic          in_lock_wait;
  logic          timeout;
  logic          pll_rst_d, sys_rst_d, ready_d, fault_d, ack_d;

`ifdef PLL_SEQ_AUTORECOVER_EN
  localparam int unsigned BACKOFF_W = 24;
  logic [BACKOFF_W-1:0] boff_q;
`endif

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign in_lock_wait = (state_q == WAIT_LOCK) || (state_q == STABLE);
  assign timeout      = in_lock_wait && (tmo_q == TW'(LOCK_TIMEOUT_CYC - 1));

  // State, counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      tmo_q         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
      relock_ack    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_cnt     <= retry_d;
      lock_loss_cnt <= llc_d;
      pll_rst       <= pll_rst_d;
      sys_rst       <= sys_rst_d;
      ready         <= ready_d;
      fault         <= fault_d;
      relock_ack    <= ack_d;
    end
  end

`ifdef PLL_SEQ_AUTORECOVER_EN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      boff_q <= '0;
    end else begin
      boff_q <= (state_q == FAULT) ? boff_q + 1'b1 : '0;
    end
  end
`endif

  // Next-state and counter datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    llc_d   = lock_loss_cnt;

    if (timeout) begin
      // Timeout wins over a STABLE completion in the same cycle.
      cnt_d = '0;
      if (retry_cnt < RW'(MAX_RETRY)) begin
        retry_d = retry_cnt + 1'b1;
        state_d = HOLD;
      end else begin
        state_d = FAULT;
      end
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CW'(RST_HOLD_CYC - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == CW'(LOCK_STABLE_CYC - 1)) begin
            state_d = RUN;
            retry_d = '0;
            cnt_d   = CW'(RESET_STRETCH_CYC - 1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          // Lock loss and relock may coincide: both take effect, one HOLD entry.
          if (!lock_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
            if (lock_loss_cnt != 8'hFF) begin
              llc_d = lock_loss_cnt + 8'd1;
            end
          end
          if (relock_req) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        FAULT: begin
          cnt_d = '0;
`ifdef PLL_SEQ_AUTORECOVER_EN
          if (&boff_q) begin
            state_d = HOLD;
            retry_d = '0;
          end
`endif
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode, registered above; the timeout count is carried only
  // while the FSM stays inside WAIT_LOCK/STABLE.
  always_comb begin
    tmo_d     = (in_lock_wait && ((state_d == WAIT_LOCK) || (state_d == STABLE))) ? tmo_q + 1'b1 : '0;
    pll_rst_d = (state_d == HOLD) || (state_d == FAULT);
    fault_d   = (state_d == FAULT);
    ack_d     = (state_q == RUN) && relock_req;
    // Core reset drops once the stretch count has expired and RUN continues.
    sys_rst_d = !((state_q == RUN) && (state_d == RUN) && (cnt_q == '0));
    ready_d   = !sys_rst_d;
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       relock_ack, pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYC      (8),
    .LOCK_STABLE_CYC   (20),
    .LOCK_TIMEOUT_CYC  (100),
    .MAX_RETRY         (3),
    .RESET_STRETCH_CYC (4)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .relock_ack    (relock_ack),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  // cyc == k after the k-th rising edge following reset release.
  always @(posedge refclk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    n_checks++;
    if ({pll_rst, sys_rst, ready, fault, relock_ack, retry_cnt, lock_loss_cnt} !== {5'b11000, 2'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got pr=%b sr=%b rdy=%b flt=%b ack=%b rc=%0d llc=%0d, want 1 1 0 0 0 0 0",
               pll_rst, sys_rst, ready, fault, relock_ack, retry_cnt, lock_loss_cnt);
    end
  endtask

  // Lock rises after edge 20: lock_s at 22, STABLE at 23, RUN at 43, ready at 47.
  task automatic test_powerup_lock();
    int t_pll, t_rdy, t_sys;
    do_reset();
    t_pll = 0; t_rdy = 0; t_sys = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (cyc == 20) pll_locked = 1'b1;
      if (!pll_rst && t_pll == 0) t_pll = cyc;
      if (ready && t_rdy == 0) t_rdy = cyc;
      if (!sys_rst && t_sys == 0) t_sys = cyc;
    end
    n_checks++;
    if (t_pll !== 8) begin n_fail++; $display("FAIL pll_rst_release: cycle %0d, want 8", t_pll); end
    n_checks++;
    if (t_rdy !== 47) begin n_fail++; $display("FAIL powerup_ready: cycle %0d, want 47", t_rdy); end
    n_checks++;
    if (t_sys !== 47) begin n_fail++; $display("FAIL powerup_sys_rst: cycle %0d, want 47", t_sys); end
    n_checks++;
    if (retry_cnt !== 2'd0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL powerup_retry: rc=%0d flt=%b, want 0 0", retry_cnt, fault);
    end
  endtask

  // Each attempt: 8 HOLD + 100 WAIT. Retries at 108/216/324, FAULT at 432.
  task automatic test_no_lock();
    int   falls, t_fault, rc_fault;
    logic prev;
    bit   stuck_ok;
    do_reset();
    falls = 0; t_fault = 0; rc_fault = 0; prev = 1'b1; stuck_ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
      if (cyc == 110) begin
        n_checks++;
        if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL retry_after_first: rc=%0d, want 1", retry_cnt); end
      end
      if (fault && t_fault == 0) begin t_fault = cyc; rc_fault = int'(retry_cnt); end
      if (t_fault != 0 && (pll_rst !== 1'b1 || fault !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0)) stuck_ok = 1'b0;
    end
    n_checks++;
    if (t_fault !== 432) begin n_fail++; $display("FAIL fault_time: cycle %0d, want 432", t_fault); end
    n_checks++;
    if (falls !== 4) begin n_fail++; $display("FAIL pll_rst_pulses: %0d, want 4", falls); end
    n_checks++;
    if (rc_fault !== 3) begin n_fail++; $display("FAIL retry_at_fault: %0d, want 3", rc_fault); end
    n_checks++;
    if (stuck_ok !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: outputs left fault state, want held"); end
  endtask

  // lock_s low only in the cycle after edge 32; STABLE restarts at 34, RUN 54, ready 58.
  task automatic test_stable_glitch();
    int t_rdy;
    do_reset();
    t_rdy = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == 20) pll_locked = 1'b1;
      if (cyc == 30) pll_locked = 1'b0;
      if (cyc == 31) pll_locked = 1'b1;
      if (ready && t_rdy == 0) t_rdy = cyc;
    end
    n_checks++;
    if (t_rdy !== 58) begin n_fail++; $display("FAIL glitch_ready: cycle %0d, want 58", t_rdy); end
    n_checks++;
    if (retry_cnt !== 2'd0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_timeout: rc=%0d flt=%b, want 0 0", retry_cnt, fault);
    end
  endtask

  // Continues from the glitch test. Drop after edge 70 for 5 cycles:
  // lock_s low at 72, HOLD at 73, WAIT 81, STABLE 82, RUN 102, ready 106.
  task automatic test_lock_loss();
    int t_sys, t_nrdy, t_rdy, llc_mid;
    t_sys = 0; t_nrdy = 0; t_rdy = 0; llc_mid = -1;
    while (cyc < 70) tick();
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL run_before_drop: ready=%b, want 1", ready); end
    pll_locked = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == 75) pll_locked = 1'b1;
      if (sys_rst && t_sys == 0) t_sys = cyc;
      if (!ready && t_nrdy == 0) t_nrdy = cyc;
      if (t_nrdy != 0 && ready && t_rdy == 0) t_rdy = cyc;
      if (cyc == 74) llc_mid = int'(lock_loss_cnt);
    end
    n_checks++;
    if (t_sys !== 73) begin n_fail++; $display("FAIL loss_sys_rst: cycle %0d, want 73", t_sys); end
    n_checks++;
    if (t_nrdy !== 73) begin n_fail++; $display("FAIL loss_ready_drop: cycle %0d, want 73", t_nrdy); end
    n_checks++;
    if (llc_mid !== 1) begin n_fail++; $display("FAIL loss_count: %0d, want 1", llc_mid); end
    n_checks++;
    if (t_rdy !== 106) begin n_fail++; $display("FAIL loss_reready: cycle %0d, want 106", t_rdy); end
  endtask

  // relock_req from edge 10 (WAIT_LOCK): no ack until RUN at 43, ack at 44,
  // then HOLD 44, WAIT 52, STABLE 53, RUN 73, ready 77.
  task automatic test_relock();
    int   t_ack, acks, t_rdy;
    logic pr_at_ack;
    do_reset();
    t_ack = 0; acks = 0; t_rdy = 0; pr_at_ack = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (cyc == 10) relock_req = 1'b1;
      if (cyc == 20) pll_locked = 1'b1;
      if (relock_ack) begin
        acks++;
        if (t_ack == 0) begin t_ack = cyc; pr_at_ack = pll_rst; end
        relock_req = 1'b0;
      end
      if (t_ack != 0 && ready && t_rdy == 0) t_rdy = cyc;
    end
    n_checks++;
    if (t_ack !== 44) begin n_fail++; $display("FAIL relock_ack_time: cycle %0d, want 44", t_ack); end
    n_checks++;
    if (acks !== 1) begin n_fail++; $display("FAIL relock_ack_count: %0d, want 1", acks); end
    n_checks++;
    if (pr_at_ack !== 1'b1) begin n_fail++; $display("FAIL relock_hold: pll_rst=%b, want 1", pr_at_ack); end
    n_checks++;
    if (t_rdy !== 77) begin n_fail++; $display("FAIL relock_ready: cycle %0d, want 77", t_rdy); end
  endtask

  // Continues at cycle 80: lock_s low at 82 and relock_req after edge 82 coincide at edge 83.
  // Single HOLD entry: WAIT 91, STABLE 92, RUN 112, ready 116.
  task automatic test_relock_with_loss();
    int   t_ack, acks, llc_at, rises, t_rdy;
    logic prev;
    t_ack = 0; acks = 0; llc_at = -1; rises = 0; t_rdy = 0;
    n_checks++;
    if (ready !== 1'b1 || cyc !== 80) begin
      n_fail++; $display("FAIL relock_loss_pre: ready=%b cyc=%0d, want 1 80", ready, cyc);
    end
    prev = pll_rst;
    pll_locked = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == 82) relock_req = 1'b1;
      if (relock_ack) begin
        acks++;
        if (t_ack == 0) begin t_ack = cyc; llc_at = int'(lock_loss_cnt); end
        relock_req = 1'b0;
        pll_locked = 1'b1;
      end
      if (!prev && pll_rst) rises++;
      prev = pll_rst;
      if (t_ack != 0 && ready && t_rdy == 0) t_rdy = cyc;
    end
    n_checks++;
    if (t_ack !== 83) begin n_fail++; $display("FAIL dual_ack_time: cycle %0d, want 83", t_ack); end
    n_checks++;
    if (acks !== 1) begin n_fail++; $display("FAIL dual_ack_count: %0d, want 1", acks); end
    n_checks++;
    if (llc_at !== 1) begin n_fail++; $display("FAIL dual_loss_count: %0d, want 1", llc_at); end
    n_checks++;
    if (rises !== 1) begin n_fail++; $display("FAIL dual_hold_entries: %0d, want 1", rises); end
    n_checks++;
    if (t_rdy !== 116) begin n_fail++; $display("FAIL dual_ready: cycle %0d, want 116", t_rdy); end
  endtask

  // 257 lock losses in RUN: counter saturates at 255. Then async reset clears it immediately.
  task automatic test_loss_saturate_and_async_reset();
    bit ok, seen;
    do_reset();
    pll_locked = 1'b1;
    ok = 1'b1;
    for (int n = 0; n < 257 && ok; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
        tick();
        if (ready) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        n_checks++; n_fail++; ok = 1'b0;
        $display("FAIL sat_wait_ready: ready=%b after 200 cycles, want 1", ready);
      end else begin
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick();
          if (!ready) begin seen = 1'b1; break; end
        end
        if (!seen) begin
          n_checks++; n_fail++; ok = 1'b0;
          $display("FAIL sat_wait_drop: ready=%b after 10 cycles, want 0", ready);
        end else if (n == 0) begin
          n_checks++;
          if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_first: llc=%0d, want 1", lock_loss_cnt); end
        end else if (n == 254) begin
          n_checks++;
          if (lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach: llc=%0d, want 255", lock_loss_cnt); end
        end
      end
    end
    n_checks++;
    if (lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: llc=%0d, want 255", lock_loss_cnt); end

    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (ready) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL async_pre_ready: ready=%b, want 1", ready); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pll_rst, sys_rst, ready, fault, relock_ack, retry_cnt, lock_loss_cnt} !== {5'b11000, 2'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got pr=%b sr=%b rdy=%b flt=%b ack=%b rc=%0d llc=%0d, want 1 1 0 0 0 0 0",
               pll_rst, sys_rst, ready, fault, relock_ack, retry_cnt, lock_loss_cnt);
    end
    @(negedge refclk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup_lock();
    test_no_lock();
    test_stable_glitch();
    test_lock_loss();
    test_relock();
    test_relock_with_loss();
    test_loss_saturate_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
